// File: rtl/otp_keypad_scanner_if.sv
`default_nettype none
// =============================================================================
// otp_keypad_scanner_if : digit/key report bus between keypad scanner and OTP FSM
// Revision 1.0
// =============================================================================
interface otp_keypad_scanner_if;
  logic [3:0] user_digit;
  logic       user_latch;
  logic [3:0] key_code;
  logic       key_held;

  modport master (
    output user_digit,
    output user_latch,
    output key_code,
    output key_held
  );

  modport slave (
    input user_digit,
    input user_latch,
    input key_code,
    input key_held
  );
endinterface
`default_nettype wire

// File: rtl/otp_keypad_scanner.sv
`default_nettype none
// =============================================================================
// otp_keypad_scanner : 4x4 active-low keypad scanner, debouncer, digit strobe
// Revision 1.0
// =============================================================================
module otp_keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 50_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  wire                  clk,
  input  wire                  reset,
  input  wire                  enable,
  input  wire  [3:0]           col_n,
  output logic [3:0]           row_n,
  otp_keypad_scanner_if.master key_if
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cap_col_q, cap_col_d;
  logic [3:0]    code_q, code_d;
  logic [3:0]    row_n_q, row_n_d;
  logic [3:0]    user_digit_q, user_digit_d;
  logic          user_latch_q, user_latch_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_held_q, key_held_d;
  logic [3:0]    col_meta_q, col_sync_q;

  logic [3:0]    col_low;
  logic          single_low;

  // Map (row, one-hot-low column) onto the keypad legend.
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [3:0] low);
    logic [1:0] col;
    logic [3:0] code;
    col = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (low[i]) col = 2'(i);
    end
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  assign col_low    = ~col_sync_q;
  assign single_low = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);

  // Columns are asynchronous to clk; pulled-up idle value is all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= col_n;
      col_sync_q <= col_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SCAN;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      cap_col_q    <= 4'hF;
      code_q       <= 4'd0;
      row_n_q      <= 4'b1110;
      user_digit_q <= 4'd0;
      user_latch_q <= 1'b0;
      key_code_q   <= 4'd0;
      key_held_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      cap_col_q    <= cap_col_d;
      code_q       <= code_d;
      row_n_q      <= row_n_d;
      user_digit_q <= user_digit_d;
      user_latch_q <= user_latch_d;
      key_code_q   <= key_code_d;
      key_held_q   <= key_held_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    cap_col_d    = cap_col_q;
    code_d       = code_q;
    user_digit_d = user_digit_q;
    user_latch_d = 1'b0;
    key_code_d   = key_code_q;
    key_held_d   = key_held_q;

    if (!enable) begin
      state_d    = SCAN;
      idx_d      = 2'd0;
      cnt_d      = '0;
      key_held_d = 1'b0;
    end else begin
      case (state_q)
        SCAN: begin
          if (cnt_q == SCAN_LAST) begin
            cnt_d = '0;
            if (single_low) begin
              cap_col_d = col_sync_q;
              code_d    = key_lookup(idx_q, col_low);
              state_d   = PRESS_DB;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        PRESS_DB: begin
          if (col_sync_q != cap_col_q) begin
            state_d = SCAN;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            cnt_d      = '0;
            state_d    = HELD;
            key_held_d = 1'b1;
            key_code_d = code_q;
            // Letters and symbols are reported on key_code only.
            if (code_q <= 4'd9) begin
              user_digit_d = code_q;
              user_latch_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        HELD: begin
          if (col_sync_q == 4'hF) begin
            state_d = RELEASE_DB;
            cnt_d   = '0;
          end
        end

        RELEASE_DB: begin
          if (col_sync_q != 4'hF) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d    = SCAN;
            cnt_d      = '0;
            key_held_d = 1'b0;
            idx_d      = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      endcase
    end

    // Row drive follows the next row index so it lines up with the counter.
    row_n_d = enable ? ~(4'b0001 << idx_d) : 4'hF;
  end

  assign row_n             = row_n_q;
  assign key_if.user_digit = user_digit_q;
  assign key_if.user_latch = user_latch_q;
  assign key_if.key_code   = key_code_q;
  assign key_if.key_held   = key_held_q;

endmodule
`default_nettype wire
